// File: rtl/up_down_counter_mod.sv
// Parametrised up/down counter with wrap or saturate, parallel load and registered boundary flags.
// Latency: 1 clk from input sample to count/flag update; no backpressure (accepts an input every cycle).
// Backpressure: none, always ready. Optional UP_DOWN_COUNTER_STICKY_EN adds sticky over/underflow flags.
module up_down_counter_mod #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             wrap,
    output logic             blocked
`ifdef UP_DOWN_COUNTER_STICKY_EN
    ,
    input  logic             clr_sticky,
    output logic             ovf_sticky,
    output logic             unf_sticky
`endif
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_zero_q, at_zero_d;
    logic             at_max_q, at_max_d;
    logic             wrap_q, wrap_d;
    logic             blocked_q, blocked_d;
    logic             at_top, at_bot;
    logic             up_bound, dn_bound;

    assign at_top   = (count_q == MAX_VAL);
    assign at_bot   = (count_q == ZERO);
    assign up_bound = !load && en && up_down && at_top;
    assign dn_bound = !load && en && !up_down && at_bot;

    // Boundaries are handled explicitly so a modulus below 2**WIDTH still wraps correctly.
    always_comb begin
        count_d   = count_q;
        wrap_d    = 1'b0;
        blocked_d = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up_down) begin
                if (!at_top) begin
                    count_d = count_q + ONE;
                end else if (SATURATE) begin
                    blocked_d = 1'b1;
                end else begin
                    count_d = ZERO;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    count_d = count_q - ONE;
                end else if (SATURATE) begin
                    blocked_d = 1'b1;
                end else begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end
            end
        end
        at_zero_d = (count_d == ZERO);
        at_max_d  = (count_d == MAX_VAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= ZERO;
            at_zero_q <= 1'b1;
            at_max_q  <= (MAX_VAL == ZERO);
            wrap_q    <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            at_zero_q <= at_zero_d;
            at_max_q  <= at_max_d;
            wrap_q    <= wrap_d;
            blocked_q <= blocked_d;
        end
    end

    assign count   = count_q;
    assign at_zero = at_zero_q;
    assign at_max  = at_max_q;
    assign wrap    = wrap_q;
    assign blocked = blocked_q;

`ifdef UP_DOWN_COUNTER_STICKY_EN
    logic ovf_sticky_q, ovf_sticky_d;
    logic unf_sticky_q, unf_sticky_d;

    // A boundary event in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        unf_sticky_d = unf_sticky_q;
        if (clr_sticky) begin
            ovf_sticky_d = 1'b0;
            unf_sticky_d = 1'b0;
        end
        if (up_bound) ovf_sticky_d = 1'b1;
        if (dn_bound) unf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;
`else
    logic unused_bounds;
    assign unused_bounds = up_bound ^ dn_bound;
`endif

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Scoreboard bench: one wrapping and one saturating counter (WIDTH=4, MAX_VAL=9) driven with shared stimulus.
module tb_up_down_counter_mod;

    localparam int W    = 4;
    localparam int MAXV = 9;

    logic         clk, rst_n, en, up_down, load, clr_sticky;
    logic [W-1:0] load_val;
    logic [W-1:0] count0, count1;
    logic         at_zero0, at_max0, wrap0, blocked0;
    logic         at_zero1, at_max1, wrap1, blocked1;
    logic         ovf0, unf0, ovf1, unf1;

    int total = 0;
    int bad   = 0;

    up_down_counter_mod #(.WIDTH(W), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .count(count0), .at_zero(at_zero0), .at_max(at_max0), .wrap(wrap0), .blocked(blocked0)
`ifdef UP_DOWN_COUNTER_STICKY_EN
        , .clr_sticky(clr_sticky), .ovf_sticky(ovf0), .unf_sticky(unf0)
`endif
    );

    up_down_counter_mod #(.WIDTH(W), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
        .count(count1), .at_zero(at_zero1), .at_max(at_max1), .wrap(wrap1), .blocked(blocked1)
`ifdef UP_DOWN_COUNTER_STICKY_EN
        , .clr_sticky(clr_sticky), .ovf_sticky(ovf1), .unf_sticky(unf1)
`endif
    );

`ifndef UP_DOWN_COUNTER_STICKY_EN
    assign ovf0 = 1'b0;
    assign unf0 = 1'b0;
    assign ovf1 = 1'b0;
    assign unf1 = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int c;
        bit w;
        bit b;
        bit o;
        bit u;
    } mst_t;

    mst_t m0, m1;
    mst_t q0[$];
    mst_t q1[$];

    // Reference: modular arithmetic for wrap, clamping for saturate.
    function automatic mst_t step(mst_t s, bit sat, bit ld, int lv, bit e, bit ud, bit clr);
        mst_t n;
        bit   bnd;
        bit   so, su;
        n   = s;
        n.w = 1'b0;
        n.b = 1'b0;
        so  = 1'b0;
        su  = 1'b0;
        if (ld) begin
            n.c = (lv > MAXV) ? MAXV : lv;
        end else if (e) begin
            bnd = ud ? (s.c == MAXV) : (s.c == 0);
            if (bnd && sat) n.b = 1'b1;
            else begin
                n.c = ud ? (s.c + 1) % (MAXV + 1) : (s.c + MAXV) % (MAXV + 1);
                n.w = bnd;
            end
            so = bnd && ud;
            su = bnd && !ud;
        end
        n.o = so ? 1'b1 : (clr ? 1'b0 : s.o);
        n.u = su ? 1'b1 : (clr ? 1'b0 : s.u);
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input mst_t e, input int c, input bit z, input bit mx,
                           input bit w, input bit b, input bit o, input bit u);
        chk({tag, ".count"},   c,  e.c);
        chk({tag, ".at_zero"}, z,  int'(e.c == 0));
        chk({tag, ".at_max"},  mx, int'(e.c == MAXV));
        chk({tag, ".wrap"},    w,  e.w);
        chk({tag, ".blocked"}, b,  e.b);
`ifdef UP_DOWN_COUNTER_STICKY_EN
        chk({tag, ".ovf_sticky"}, o, e.o);
        chk({tag, ".unf_sticky"}, u, e.u);
`endif
    endtask

    // Monitor: every registered output update is compared against the queued expectation.
    initial begin
        mst_t e0, e1;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk_dut("wrap_dut", e0, int'(count0), at_zero0, at_max0, wrap0, blocked0, ovf0, unf0);
                chk_dut("sat_dut",  e1, int'(count1), at_zero1, at_max1, wrap1, blocked1, ovf1, unf1);
            end
        end
    end

    task automatic model_reset();
        m0 = '{c: 0, w: 1'b0, b: 1'b0, o: 1'b0, u: 1'b0};
        m1 = m0;
    endtask

    task automatic cyc(input bit ld, input int lv, input bit e, input bit ud, input bit clr);
        @(negedge clk);
        load       = ld;
        load_val   = W'(lv);
        en         = e;
        up_down    = ud;
        clr_sticky = clr;
        m0 = step(m0, 1'b0, ld, lv, e, ud, clr);
        m1 = step(m1, 1'b1, ld, lv, e, ud, clr);
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n      = 1'b0;
        en         = 1'b0;
        load       = 1'b0;
        clr_sticky = 1'b0;
        #1;
        model_reset();
        chk_dut("rst_wrap", m0, int'(count0), at_zero0, at_max0, wrap0, blocked0, ovf0, unf0);
        chk_dut("rst_sat",  m1, int'(count1), at_zero1, at_max1, wrap1, blocked1, ovf1, unf1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int waited;
        rst_n      = 1'b0;
        en         = 1'b0;
        up_down    = 1'b0;
        load       = 1'b0;
        load_val   = '0;
        clr_sticky = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_dut("reset_wrap", m0, int'(count0), at_zero0, at_max0, wrap0, blocked0, ovf0, unf0);
        chk_dut("reset_sat",  m1, int'(count1), at_zero1, at_max1, wrap1, blocked1, ovf1, unf1);
        rst_n = 1'b1;

        repeat (10) cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 9, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 15, 1'b1, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 6, 1'b0, 1'b0, 1'b0);
        async_reset();
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            cyc($urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
                $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
        end

        waited = 0;
        while (q0.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (q0.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q0.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
